// File: rtl/mem_ctrl_pkg.sv
// Shared types for the operand memory controller: FSM state and command
// encodings, plus a constant-evaluable clog2 used to size address fields.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STORE  = 2'b01,
    ST_STREAM = 2'b10,
    ST_WAIT   = 2'b11
  } mc_state_e;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_LOAD   = 2'b01,
    CMD_STREAM = 2'b10,
    CMD_ABORT  = 2'b11
  } mc_cmd_e;

  function automatic int unsigned mc_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/opnd_mem_ctrl_if.sv
// Write-side and read-side handshake bundle of the operand memory controller.
// master: core/PU side; slave: the controller.
interface opnd_mem_ctrl_if #(
  parameter int unsigned DW  = 128,
  parameter int unsigned NCH = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [NCH*DW-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [NCH*DW-1:0] out_data;
  logic              out_burst_end;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_burst_end, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_burst_end, out_last
  );
endinterface

// File: rtl/opnd_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port (1-cycle latency).
// Contents are not reset.
module opnd_ram
  import mem_ctrl_pkg::*;
#(
  parameter  int unsigned WIDTH = 256,
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = mc_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/opnd_mem_ctrl.sv
// Operand memory controller: buffers NCH operand channels into RAM, then streams
// them to the PUs in bursts of BURST with valid/ready on both sides.
// Optional feature macro: MC_PARITY_EN (per-channel even parity, sticky mc_err).
module opnd_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter  int unsigned DW    = 128,
  parameter  int unsigned NCH   = 2,
  parameter  int unsigned DEPTH = 32,
  parameter  int unsigned BURST = 4,
  localparam int unsigned AW    = mc_clog2(DEPTH)
) (
  input  logic                 mc_clk,
  input  logic                 mc_reset,
  input  logic [1:0]           mc_cmd,
  input  logic [AW:0]          mc_length,
  opnd_mem_ctrl_if.slave       bus,
  input  logic                 pu_done,
  output logic                 mc_busy,
  output logic                 mc_done,
  output logic [1:0]           mc_state,
  output logic                 mc_err
);

`ifdef MC_PARITY_EN
  localparam int unsigned CW = DW + 1;
`else
  localparam int unsigned CW = DW;
`endif
  localparam int unsigned RW      = NCH * CW;
  localparam int unsigned WD      = NCH * DW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] BURST_L = (AW+1)'(BURST);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  mc_state_e   state_q, state_d;
  logic [AW:0] len_q, wr_ptr_q, rd_ptr_q, biss_q, len_eff;
  logic        loaded_q, done_q;
  logic        abort, wr_en, rd_en, pop, push;
  logic        load_go, stream_go, store_last, acc_last, enter_wait;
  logic        issue_last, issue_bend;
  logic        rd_pend_q, rd_last_q, rd_bend_q;
  logic [RW-1:0] wdata, rdata;
  logic [WD-1:0] rdata_pl;

  // Two-entry skid buffer behind the RAM read port.
  logic [WD-1:0] sk_data_q [2];
  logic          sk_last_q [2];
  logic          sk_bend_q [2];
  logic          sk_rd_q, sk_wr_q;
  logic [1:0]    sk_cnt_q, occ;
  logic          head_last, head_bend;

  assign occ        = sk_cnt_q + {1'b0, rd_pend_q};
  assign push       = rd_pend_q && !abort;
  assign issue_last = (rd_ptr_q == len_q - ONE);
  assign issue_bend = issue_last || (biss_q == BURST_L - ONE);
  assign head_last  = sk_last_q[sk_rd_q];
  assign head_bend  = sk_bend_q[sk_rd_q];

  assign bus.out_data      = sk_data_q[sk_rd_q];
  assign bus.out_last      = bus.out_valid && head_last;
  assign bus.out_burst_end = bus.out_valid && head_bend;
  assign mc_busy           = (state_q != ST_IDLE);
  assign mc_done           = done_q;
  assign mc_state          = state_q;

  // Zero or oversize transfer length selects the whole RAM.
  always_comb begin
    len_eff = mc_length;
    if (mc_length == '0 || mc_length > DEPTH_L) len_eff = DEPTH_L;
  end

  // Next-state and handshake decode; ABORT outside IDLE overrides everything.
  always_comb begin
    state_d       = state_q;
    abort         = 1'b0;
    wr_en         = 1'b0;
    rd_en         = 1'b0;
    pop           = 1'b0;
    load_go       = 1'b0;
    stream_go     = 1'b0;
    store_last    = 1'b0;
    acc_last      = 1'b0;
    enter_wait    = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mc_cmd == CMD_LOAD) begin
          load_go = 1'b1;
          state_d = ST_STORE;
        end else if (mc_cmd == CMD_STREAM && loaded_q) begin
          stream_go = 1'b1;
          state_d   = ST_STREAM;
        end
      end
      ST_STORE: begin
        abort        = (mc_cmd == CMD_ABORT);
        bus.in_ready = !abort;
        wr_en        = bus.in_valid && !abort;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (wr_en && wr_ptr_q == len_q - ONE) begin
          store_last = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_STREAM: begin
        abort         = (mc_cmd == CMD_ABORT);
        bus.out_valid = (sk_cnt_q != 2'd0);
        pop           = bus.out_valid && bus.out_ready && !abort;
        // Room check counts the beat leaving this cycle so the pipe sustains 1 beat/cycle.
        rd_en = !abort && (rd_ptr_q < len_q) && (biss_q < BURST_L) &&
                ((occ - {1'b0, pop}) < 2'd2);
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pop && head_last) begin
          acc_last = 1'b1;
          state_d  = ST_IDLE;
        end else if (pop && head_bend) begin
          enter_wait = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        abort = (mc_cmd == CMD_ABORT);
        if (abort) state_d = ST_IDLE;
        else if (pu_done) state_d = ST_STREAM;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge mc_clk) begin
    if (mc_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Transfer length, pointers, burst counter, loaded flag and done pulse.
  always_ff @(posedge mc_clk) begin
    if (mc_reset) begin
      len_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      biss_q    <= '0;
      loaded_q  <= 1'b0;
      done_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
      rd_bend_q <= 1'b0;
    end else begin
      done_q    <= store_last || acc_last;
      rd_pend_q <= rd_en;
      if (load_go) begin
        len_q    <= len_eff;
        wr_ptr_q <= '0;
        loaded_q <= 1'b0;
      end
      if (wr_en) wr_ptr_q <= wr_ptr_q + ONE;
      if (store_last) loaded_q <= 1'b1;
      if (abort) loaded_q <= 1'b0;
      if (stream_go) begin
        rd_ptr_q <= '0;
        biss_q   <= '0;
      end
      if (rd_en) begin
        rd_ptr_q  <= rd_ptr_q + ONE;
        biss_q    <= biss_q + ONE;
        rd_last_q <= issue_last;
        rd_bend_q <= issue_bend;
      end
      if (enter_wait) biss_q <= '0;
    end
  end

  // Skid buffer: push returning RAM data, pop on accepted beat, flush on abort.
  always_ff @(posedge mc_clk) begin
    if (mc_reset || abort) begin
      sk_cnt_q <= '0;
      sk_rd_q  <= 1'b0;
      sk_wr_q  <= 1'b0;
      if (mc_reset) begin
        sk_data_q[0] <= '0;
        sk_data_q[1] <= '0;
        sk_last_q[0] <= 1'b0;
        sk_last_q[1] <= 1'b0;
        sk_bend_q[0] <= 1'b0;
        sk_bend_q[1] <= 1'b0;
      end
    end else begin
      if (push) begin
        sk_data_q[sk_wr_q] <= rdata_pl;
        sk_last_q[sk_wr_q] <= rd_last_q;
        sk_bend_q[sk_wr_q] <= rd_bend_q;
        sk_wr_q            <= ~sk_wr_q;
      end
      if (pop) sk_rd_q <= ~sk_rd_q;
      sk_cnt_q <= sk_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef MC_PARITY_EN
  logic par_bad, err_q;

  // Per-channel even parity appended on write and checked on read.
  always_comb begin
    wdata    = '0;
    rdata_pl = '0;
    par_bad  = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      wdata[k*CW +: CW]    = {^bus.in_data[k*DW +: DW], bus.in_data[k*DW +: DW]};
      rdata_pl[k*DW +: DW] = rdata[k*CW +: DW];
      if (^rdata[k*CW +: CW]) par_bad = 1'b1;
    end
  end

  // Sticky parity error, cleared when a new LOAD starts.
  always_ff @(posedge mc_clk) begin
    if (mc_reset)              err_q <= 1'b0;
    else if (load_go)          err_q <= 1'b0;
    else if (push && par_bad)  err_q <= 1'b1;
  end

  assign mc_err = err_q;
`else
  assign wdata    = bus.in_data;
  assign rdata_pl = rdata;
  assign mc_err   = 1'b0;
`endif

  opnd_ram #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (mc_clk),
    .we    (wr_en),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_opnd_mem_ctrl.sv
// Self-checking bench for opnd_mem_ctrl: table of load/stream transfers with a
// scoreboard queue, plus hand-written abort, reset and parity sequences.
module tb_opnd_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned NCH   = 2;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned BURST = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned WD    = NCH * DW;

  logic          mc_clk = 1'b0;
  logic          mc_reset;
  logic [1:0]    mc_cmd;
  logic [AW:0]   mc_length;
  logic          pu_done;
  logic          mc_busy, mc_done, mc_err;
  logic [1:0]    mc_state;

  opnd_mem_ctrl_if #(.DW(DW), .NCH(NCH)) bus ();

  opnd_mem_ctrl #(
    .DW    (DW),
    .NCH   (NCH),
    .DEPTH (DEPTH),
    .BURST (BURST)
  ) dut (
    .mc_clk    (mc_clk),
    .mc_reset  (mc_reset),
    .mc_cmd    (mc_cmd),
    .mc_length (mc_length),
    .bus       (bus),
    .pu_done   (pu_done),
    .mc_busy   (mc_busy),
    .mc_done   (mc_done),
    .mc_state  (mc_state),
    .mc_err    (mc_err)
  );

  always #5 mc_clk = ~mc_clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [WD-1:0] model_mem [DEPTH];
  logic [WD-1:0] sb [$];

  typedef struct {
    int unsigned len_in;
    int unsigned exp_len;
    bit          reload;
    int unsigned in_mode;   // 0 full-rate writes, 1 random gaps
    int unsigned rdy_mode;  // 0 always ready, 1 toggling, 2 random
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [WD-1:0] ram_word(input int unsigned a);
    logic [WD-1:0] r;
`ifdef MC_PARITY_EN
    logic [NCH*(DW+1)-1:0] w;
    w = dut.u_ram.mem[a];
    for (int unsigned k = 0; k < NCH; k++) r[k*DW +: DW] = w[k*(DW+1) +: DW];
`else
    r = dut.u_ram.mem[a];
`endif
    return r;
  endfunction

  task automatic do_load(input int unsigned len_in, input int unsigned eff, input int unsigned in_mode);
    int unsigned beats, cyc;
    beats = 0;
    cyc   = 0;
    @(negedge mc_clk);
    mc_cmd    = CMD_LOAD;
    mc_length = len_in[AW:0];
    @(negedge mc_clk);
    mc_cmd = CMD_NOP;
    while (beats < eff && cyc < 500) begin
      bus.in_valid = (in_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      bus.in_data  = WD'($urandom);
      #1;
      if (cyc == 0) chk("store_state", 64'(mc_state), 64'(ST_STORE));
      chk("in_ready_store", 64'(bus.in_ready), 64'(1));
      if (bus.in_valid && bus.in_ready) begin
        model_mem[beats] = bus.in_data;
        beats++;
      end
      cyc++;
      @(negedge mc_clk);
    end
    bus.in_valid = 1'b0;
    if (beats < eff) chk("load_timeout", 64'(beats), 64'(eff));
    #1;
    chk("load_done", 64'(mc_done), 64'(1));
    chk("load_idle", 64'(mc_state), 64'(ST_IDLE));
    chk("in_ready_after", 64'(bus.in_ready), 64'(0));
    @(negedge mc_clk);
    #1;
    chk("load_done_pulse", 64'(mc_done), 64'(0));
  endtask

  task automatic do_stream(input int unsigned eff, input int unsigned rmode);
    int unsigned   idx, inb, cyc;
    bit            prev_stall, fin;
    logic [WD-1:0] prev_data, exp;
    for (int unsigned i = 0; i < eff; i++) sb.push_back(model_mem[i]);
    idx = 0; inb = 0; cyc = 0; prev_stall = 0; fin = 0; prev_data = '0;
    @(negedge mc_clk);
    mc_cmd        = CMD_STREAM;
    bus.out_ready = 1'b0;
    @(negedge mc_clk);
    mc_cmd = CMD_NOP;
    #1;
    chk("stream_state", 64'(mc_state), 64'(ST_STREAM));
    while (!fin && cyc < 1000) begin
      @(negedge mc_clk);
      pu_done = 1'b0;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = cyc[0];
        default: bus.out_ready = ($urandom_range(0, 1) != 0);
      endcase
      #1;
      cyc++;
      if (prev_stall) begin
        chk("hold_valid", 64'(bus.out_valid), 64'(1));
        chk("hold_data", 64'(bus.out_data), 64'(prev_data));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_beat", 64'(1), 64'(0));
        end else begin
          exp = sb.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(exp));
          chk("out_last", 64'(bus.out_last), 64'(idx == eff - 1));
          chk("out_burst_end", 64'(bus.out_burst_end),
              64'((idx == eff - 1) || (inb == BURST - 1)));
        end
        idx++;
        inb++;
        if (idx == eff) begin
          fin = 1;
          @(negedge mc_clk);
          #1;
          chk("stream_done", 64'(mc_done), 64'(1));
          chk("stream_idle", 64'(mc_state), 64'(ST_IDLE));
          chk("stream_valid_off", 64'(bus.out_valid), 64'(0));
          @(negedge mc_clk);
          #1;
          chk("stream_done_pulse", 64'(mc_done), 64'(0));
        end else if (inb == BURST) begin
          inb = 0;
          prev_stall = 0;
          @(negedge mc_clk);
          #1;
          chk("wait_state", 64'(mc_state), 64'(ST_WAIT));
          chk("wait_valid", 64'(bus.out_valid), 64'(0));
          @(negedge mc_clk);
          #1;
          chk("wait_hold", 64'(mc_state), 64'(ST_WAIT));
          @(negedge mc_clk);
          pu_done = 1'b1;
          #1;
          chk("wait_valid_pu", 64'(bus.out_valid), 64'(0));
        end
      end
    end
    pu_done = 1'b0;
    if (!fin) chk("stream_timeout", 64'(idx), 64'(eff));
    chk("sb_empty", 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WD-1:0] old2;
    int unsigned   acc, cyc;

    vecs[0] = '{5,  5,  1'b1, 0, 0};
    vecs[1] = '{5,  5,  1'b0, 0, 1};
    vecs[2] = '{0,  32, 1'b1, 0, 0};
    vecs[3] = '{40, 32, 1'b1, 1, 2};
    vecs[4] = '{1,  1,  1'b1, 0, 1};
    vecs[5] = '{4,  4,  1'b1, 1, 0};
    vecs[6] = '{9,  9,  1'b1, 0, 2};

    mc_reset      = 1'b1;
    mc_cmd        = CMD_NOP;
    mc_length     = '0;
    pu_done       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge mc_clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_last", 64'(bus.out_last), 64'(0));
    chk("rst_burst_end", 64'(bus.out_burst_end), 64'(0));
    chk("rst_busy", 64'(mc_busy), 64'(0));
    chk("rst_done", 64'(mc_done), 64'(0));
    chk("rst_state", 64'(mc_state), 64'(ST_IDLE));
    chk("rst_err", 64'(mc_err), 64'(0));
    @(negedge mc_clk);
    mc_reset = 1'b0;

    // STREAM before any LOAD is ignored.
    @(negedge mc_clk);
    mc_cmd = CMD_STREAM;
    @(negedge mc_clk);
    mc_cmd = CMD_NOP;
    #1;
    chk("stream_unloaded", 64'(mc_state), 64'(ST_IDLE));

    for (int unsigned v = 0; v < 7; v++) begin
      if (vecs[v].reload) do_load(vecs[v].len_in, vecs[v].exp_len, vecs[v].in_mode);
      do_stream(vecs[v].exp_len, vecs[v].rdy_mode);
    end

    // ABORT on the third STORE beat: beat dropped, loaded flag cleared.
    old2 = model_mem[2];
    @(negedge mc_clk);
    mc_cmd    = CMD_LOAD;
    mc_length = 6'd5;
    @(negedge mc_clk);
    mc_cmd       = CMD_NOP;
    bus.in_valid = 1'b1;
    bus.in_data  = WD'($urandom);
    model_mem[0] = bus.in_data;
    @(negedge mc_clk);
    bus.in_data  = WD'($urandom);
    model_mem[1] = bus.in_data;
    @(negedge mc_clk);
    mc_cmd      = CMD_ABORT;
    bus.in_data = ~old2;
    #1;
    chk("abort_in_ready", 64'(bus.in_ready), 64'(0));
    @(negedge mc_clk);
    mc_cmd       = CMD_NOP;
    bus.in_valid = 1'b0;
    pu_done      = 1'b1;
    #1;
    chk("abort_idle", 64'(mc_state), 64'(ST_IDLE));
    chk("abort_no_done", 64'(mc_done), 64'(0));
    chk("abort_busy", 64'(mc_busy), 64'(0));
    @(negedge mc_clk);
    pu_done = 1'b0;
    #1;
    chk("pu_done_idle", 64'(mc_state), 64'(ST_IDLE));
    chk("abort_not_written", 64'(ram_word(2)), 64'(old2));
    chk("abort_beat1_written", 64'(ram_word(1)), 64'(model_mem[1]));
    @(negedge mc_clk);
    mc_cmd = CMD_STREAM;
    @(negedge mc_clk);
    mc_cmd = CMD_NOP;
    #1;
    chk("stream_after_abort", 64'(mc_state), 64'(ST_IDLE));

    // ABORT in the middle of a STREAM burst.
    do_load(9, 9, 0);
    @(negedge mc_clk);
    mc_cmd        = CMD_STREAM;
    bus.out_ready = 1'b1;
    @(negedge mc_clk);
    mc_cmd = CMD_NOP;
    acc = 0;
    cyc = 0;
    while (acc < 2 && cyc < 50) begin
      @(negedge mc_clk);
      #1;
      cyc++;
      if (bus.out_valid && bus.out_ready) begin
        chk("abort_stream_data", 64'(bus.out_data), 64'(model_mem[acc]));
        acc++;
      end
    end
    if (acc < 2) chk("abort_stream_timeout", 64'(acc), 64'(2));
    @(negedge mc_clk);
    mc_cmd = CMD_ABORT;
    @(negedge mc_clk);
    mc_cmd = CMD_NOP;
    #1;
    chk("sabort_valid", 64'(bus.out_valid), 64'(0));
    chk("sabort_idle", 64'(mc_state), 64'(ST_IDLE));
    chk("sabort_no_done", 64'(mc_done), 64'(0));
    @(negedge mc_clk);
    mc_cmd = CMD_STREAM;
    @(negedge mc_clk);
    mc_cmd = CMD_NOP;
    #1;
    chk("sabort_replay_blocked", 64'(mc_state), 64'(ST_IDLE));

    // Synchronous reset during STREAM aborts silently and clears the loaded flag.
    do_load(6, 6, 0);
    @(negedge mc_clk);
    mc_cmd = CMD_STREAM;
    @(negedge mc_clk);
    mc_cmd = CMD_NOP;
    repeat (3) @(negedge mc_clk);
    mc_reset = 1'b1;
    @(negedge mc_clk);
    #1;
    chk("mrst_state", 64'(mc_state), 64'(ST_IDLE));
    chk("mrst_valid", 64'(bus.out_valid), 64'(0));
    chk("mrst_data", 64'(bus.out_data), 64'(0));
    chk("mrst_done", 64'(mc_done), 64'(0));
    @(negedge mc_clk);
    mc_reset = 1'b0;
    mc_cmd   = CMD_STREAM;
    @(negedge mc_clk);
    mc_cmd = CMD_NOP;
    #1;
    chk("mrst_stream_blocked", 64'(mc_state), 64'(ST_IDLE));

`ifdef MC_PARITY_EN
    // Corrupt one stored bit: data still delivered, sticky error until next LOAD.
    do_load(3, 3, 0);
    chk("par_clean", 64'(mc_err), 64'(0));
    dut.u_ram.mem[1][0] = ~dut.u_ram.mem[1][0];
    model_mem[1][0]     = ~model_mem[1][0];
    do_stream(3, 0);
    chk("par_err_set", 64'(mc_err), 64'(1));
    repeat (3) @(negedge mc_clk);
    #1;
    chk("par_err_sticky", 64'(mc_err), 64'(1));
    do_load(2, 2, 0);
    chk("par_err_cleared", 64'(mc_err), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
